mem_port_arbiter: RTL

Two-port memory access controller sitting between the control unit's instruction-fetch path, the datapath's load/store path and the single shared byte-addressed RAM. It arbitrates between the two requesters, drives the RAM port for a programmable number of wait cycles, and returns read data with a one-cycle memory-function-complete (MFC) pulse to the granted requester. It also rejects misaligned or invalid accesses without touching the RAM.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus of the two-port memory arbiter: fetch port, data port and shared RAM port.
// The arbiter uses the slave view; the surrounding control unit, datapath and RAM use the master view.
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 8
);
   logic          f_mfa;
   logic [AW-1:0] f_addr;
   logic [31:0]   f_rdata;
   logic          f_mfc;
   logic          f_err;

   logic          d_mfa;
   logic          d_rw;
   logic [1:0]    d_size;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [31:0]   d_rdata;
   logic          d_mfc;
   logic          d_err;

   logic          ram_en;
   logic          ram_rw;
   logic [1:0]    ram_size;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;

   modport slave (
      input  f_mfa, f_addr, d_mfa, d_rw, d_size, d_addr, d_wdata, ram_rdata,
      output f_rdata, f_mfc, f_err, d_rdata, d_mfc, d_err,
             ram_en, ram_rw, ram_size, ram_addr, ram_wdata
   );

   modport master (
      output f_mfa, f_addr, d_mfa, d_rw, d_size, d_addr, d_wdata, ram_rdata,
      input  f_rdata, f_mfc, f_err, d_rdata, d_mfc, d_err,
             ram_en, ram_rw, ram_size, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one byte-addressed RAM, holding the RAM port for
// WAIT+1 cycles per access and returning a one-cycle MFC pulse (with error flag) to the winner.
module mem_port_arbiter #(
   parameter int unsigned AW   = 8,
   parameter int unsigned WAIT = 2
) (
   input logic               CLK,
   input logic               Reset,
   mem_port_arbiter_if.slave bus
);
   // REJECT is a one-cycle turnaround so rejected accesses report after the second edge.
   typedef enum logic [1:0] {IDLE, ACCESS, REJECT, DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          gnt_q, gnt_d;
   logic          last_gnt_q, last_gnt_d;
   logic          err_q, err_d;
   logic          rw_q, rw_d;
   logic [1:0]    size_q, size_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          take_f, take_d, bad;
   logic          in_access, in_done;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      err_d      = err_q;
      rw_d       = rw_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      take_f     = 1'b0;
      take_d     = 1'b0;
      bad        = 1'b0;

      unique case (state_q)
         IDLE: begin
            // On a tie the port that did not win last time goes first.
            take_d = bus.d_mfa & (~bus.f_mfa | ~last_gnt_q);
            take_f = bus.f_mfa & ~take_d;
            if (take_d) begin
               rw_d    = bus.d_rw;
               size_d  = bus.d_size;
               addr_d  = bus.d_addr;
               wdata_d = bus.d_wdata;
               bad     = (bus.d_size == 2'b11) ||
                         (bus.d_size == 2'b01 && bus.d_addr[0]) ||
                         (bus.d_size == 2'b10 && bus.d_addr[1:0] != 2'b00);
            end else if (take_f) begin
               rw_d    = 1'b0;
               size_d  = 2'b10;
               addr_d  = bus.f_addr;
               wdata_d = '0;
               bad     = (bus.f_addr[1:0] != 2'b00);
            end
            if (take_f || take_d) begin
               gnt_d      = take_d;
               last_gnt_d = take_d;
               err_d      = bad;
               rdata_d    = '0;
               cnt_d      = 4'(WAIT);
               state_d    = bad ? REJECT : ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = DONE;
               if (!rw_q) begin
                  unique case (size_q)
                     2'b00:   rdata_d = {24'b0, bus.ram_rdata[7:0]};
                     2'b01:   rdata_d = {16'b0, bus.ram_rdata[15:0]};
                     default: rdata_d = bus.ram_rdata;
                  endcase
               end
            end
         end
         REJECT:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         gnt_q      <= 1'b0;
         last_gnt_q <= 1'b0;
         err_q      <= 1'b0;
         rw_q       <= 1'b0;
         size_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
         err_q      <= err_d;
         rw_q       <= rw_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   // Outputs decode only from flops, so nothing combinational reaches them from the inputs.
   assign in_access = (state_q == ACCESS);
   assign in_done   = (state_q == DONE);

   assign bus.ram_en    = in_access;
   assign bus.ram_rw    = in_access & rw_q;
   assign bus.ram_size  = in_access ? size_q : '0;
   assign bus.ram_addr  = in_access ? addr_q : '0;
   assign bus.ram_wdata = (in_access & rw_q) ? wdata_q : '0;

   assign bus.f_mfc   = in_done & ~gnt_q;
   assign bus.f_err   = in_done & ~gnt_q & err_q;
   assign bus.f_rdata = (in_done & ~gnt_q) ? rdata_q : '0;

   assign bus.d_mfc   = in_done & gnt_q;
   assign bus.d_err   = in_done & gnt_q & err_q;
   assign bus.d_rdata = (in_done & gnt_q) ? rdata_q : '0;
endmodule
